vmul8_dot_seq: RTL and testbench

- Sequencer and accumulator wrapped around the 8x8 signed Booth multiplier `mult_8b`.
- Accepts beats of ELEMS packed signed byte pairs. Issues one pair per cycle to the multiplier. Consumes each 16-bit product one cycle later and accumulates a signed dot product.
- Presents the dot product on a ready/valid output at end of vector.
- Lives in the vector MAC/reduction path. `mult_8b` is instantiated beside it by the parent and wired to the mul_* ports.

---
 rtl/vmul8_dot_seq_pkg.sv | 7 +
 rtl/vmul8_dot_seq_if.sv | 36 +++
 rtl/vmul8_dot_seq.sv | 102 ++++++++++
 tb/tb_vmul8_dot_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmul8_dot_seq_pkg.sv
// Shared types and fixed widths for the vmul8 dot-product sequencer.
package vmul_pkg;
  localparam int DATA_WTH = 8;
  localparam int RES_WTH  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} vmul_state_t;
endpackage

// File: rtl/vmul8_dot_seq_if.sv
// Beat input, multiplier side-channel and result output of the dot-product sequencer.
interface vmul8_dot_seq_if
  import vmul_pkg::*;
#(
  parameter int ELEMS   = 4,
  parameter int ACC_WTH = 24
) ();
  logic                      in_vld;
  logic                      in_rdy;
  logic [ELEMS*DATA_WTH-1:0] in_a;
  logic [ELEMS*DATA_WTH-1:0] in_b;
  logic                      in_first;
  logic                      in_last;

  logic                      mul_vld;
  logic [DATA_WTH-1:0]       mul_a;
  logic [DATA_WTH-1:0]       mul_b;
  logic [RES_WTH-1:0]        mul_d;

  logic                      out_vld;
  logic                      out_rdy;
  logic [ACC_WTH-1:0]        out_acc;
  logic                      out_ovf;

  // Block side: consumes beats and products, produces operands and results.
  modport slave (
    input  in_vld, in_a, in_b, in_first, in_last, mul_d, out_rdy,
    output in_rdy, mul_vld, mul_a, mul_b, out_vld, out_acc, out_ovf
  );

  // Parent side: feeds beats, hosts the multiplier, takes results.
  modport master (
    output in_vld, in_a, in_b, in_first, in_last, mul_d, out_rdy,
    input  in_rdy, mul_vld, mul_a, mul_b, out_vld, out_acc, out_ovf
  );
endinterface

// File: rtl/vmul8_dot_seq.sv
// Issues ELEMS byte pairs per beat to an external 1-cycle multiplier and accumulates a signed dot product.
// Beat-to-ready ELEMS+2 cycles; a last beat then holds the result in OUT until out_rdy.
module vmul8_dot_seq
  import vmul_pkg::*;
#(
  parameter int ELEMS   = 4,
  parameter int ACC_WTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  vmul8_dot_seq_if.slave   io
);
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

  vmul_state_t               state;
  logic [ELEMS*DATA_WTH-1:0] a_q;
  logic [ELEMS*DATA_WTH-1:0] b_q;
  logic                      last_q;
  logic [IDX_W-1:0]          idx;
  logic                      pv;
  logic [ACC_WTH-1:0]        acc;
  logic                      ovf;

  logic [DATA_WTH-1:0]       sel_a;
  logic [DATA_WTH-1:0]       sel_b;
  logic [ACC_WTH-1:0]        prod_ext;
  logic [ACC_WTH-1:0]        sum;
  logic                      add_ovf;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < ELEMS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_a = a_q[i*DATA_WTH +: DATA_WTH];
        sel_b = b_q[i*DATA_WTH +: DATA_WTH];
      end
    end
  end

  assign prod_ext = {{(ACC_WTH-RES_WTH){io.mul_d[RES_WTH-1]}}, io.mul_d};
  assign sum      = acc + prod_ext;
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign add_ovf  = (acc[ACC_WTH-1] == prod_ext[ACC_WTH-1]) &&
                    (sum[ACC_WTH-1] != acc[ACC_WTH-1]);

  assign io.in_rdy  = (state == IDLE);
  assign io.mul_vld = (state == ISSUE);
  assign io.mul_a   = (state == ISSUE) ? sel_a : '0;
  assign io.mul_b   = (state == ISSUE) ? sel_b : '0;
  assign io.out_vld = (state == OUT);
  assign io.out_acc = (state == OUT) ? acc : '0;
  assign io.out_ovf = (state == OUT) && ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      idx    <= '0;
      pv     <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      // Product issued last cycle is valid on mul_d now.
      pv <= (state == ISSUE);
      if (pv) begin
        acc <= sum;
        ovf <= ovf | add_ovf;
      end

      case (state)
        IDLE: begin
          if (io.in_vld) begin
            a_q    <= io.in_a;
            b_q    <= io.in_b;
            last_q <= io.in_last;
            idx    <= '0;
            if (io.in_first) begin
              acc <= '0;
              ovf <= 1'b0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          state <= last_q ? OUT : IDLE;
        end
        OUT: begin
          if (io.out_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vmul8_dot_seq.sv
// Bench for vmul8_dot_seq: hosts a behavioural 1-cycle multiplier and checks against an arithmetic model.
module tb_vmul8_dot_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vmul8_dot_seq_if #(.ELEMS(4), .ACC_WTH(24)) bus ();
  vmul8_dot_seq #(.ELEMS(4), .ACC_WTH(24)) dut (.clk(clk), .rst(rst), .io(bus));

  function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    int x;
    int y;
    sa = a;
    sb = b;
    x = sa;
    y = sb;
    return 16'(x * y);
  endfunction

  // Stand-in for mult_8b: product of the pair presented one cycle earlier.
  always @(posedge clk) bus.mul_d <= bus.mul_vld ? mul16(bus.mul_a, bus.mul_b) : 16'h0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  function automatic void model_beat(input logic [31:0] a, input logic [31:0] b, input logic f);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    longint x;
    longint y;
    longint s;
    if (f) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      sa = a[i*8 +: 8];
      sb = b[i*8 +: 8];
      x = sa;
      y = sb;
      s = m_acc + x * y;
      if (s > 8388607 || s < -8388608) m_ovf = 1'b1;
      s = s & 64'hFFFFFF;
      if (s >= 8388608) s = s - 16777216;
      m_acc = s;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l);
    int n;
    n = 0;
    while (!bus.in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_rdy) chk("in_rdy_timeout", 0, 1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_first = f;
    bus.in_last = l;
    bus.in_vld = 1'b1;
    @(negedge clk);
    bus.in_vld = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic get_result(input string nm, input int delay, output longint acc, output logic ovf);
    int n;
    n = 0;
    while (!bus.out_vld && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_vld) chk({nm, "_out_vld_timeout"}, 0, 1);
    repeat (delay) @(negedge clk);
    acc = $signed(bus.out_acc);
    ovf = bus.out_ovf;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic        f;
    logic        l;
    longint      exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    longint racc;
    logic   rovf;
    int     mv_cnt;
    bit     early;
    logic [31:0] ra;
    logic [31:0] rb;
    logic   rf;
    logic   rl;

    tbl[0] = '{"t1_single",   32'h04030201, 32'h08070605, 1'b1, 1'b1, 70,     1'b0};
    tbl[1] = '{"signed",      32'h027F80FF, 32'hFE7F8001, 1'b1, 1'b1, 32508,  1'b0};
    tbl[2] = '{"two_beat_b1", 32'h04030201, 32'h08070605, 1'b1, 1'b0, 0,      1'b0};
    tbl[3] = '{"two_beat_b2", 32'h01010101, 32'h01010101, 1'b0, 1'b1, 74,     1'b0};
    tbl[4] = '{"after_out",   32'h01010101, 32'h01010101, 1'b0, 1'b1, 78,     1'b0};
    tbl[5] = '{"neg_sum",     32'h7F7F7F7F, 32'h81818181, 1'b1, 1'b1, -64516, 1'b0};

    bus.in_vld = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_first = 1'b0;
    bus.in_last = 1'b0;
    bus.out_rdy = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_mul_vld", bus.mul_vld, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_acc", bus.out_acc, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      send(tbl[t].a, tbl[t].b, tbl[t].f, tbl[t].l);
      chk({tbl[t].nm, "_mul_vld_c1"}, bus.mul_vld, 1);
      chk({tbl[t].nm, "_mul_a_c1"}, bus.mul_a, tbl[t].a[7:0]);
      mv_cnt = 0;
      early = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        if (bus.mul_vld) mv_cnt++;
        if (bus.out_vld) early = 1'b1;
        @(negedge clk);
      end
      chk({tbl[t].nm, "_mul_vld_cycles"}, mv_cnt, 4);
      chk({tbl[t].nm, "_out_vld_early"}, early, 0);
      if (tbl[t].l) begin
        chk({tbl[t].nm, "_out_vld_c6"}, bus.out_vld, 1);
        chk({tbl[t].nm, "_acc"}, $signed(bus.out_acc), tbl[t].exp_acc);
        chk({tbl[t].nm, "_ovf"}, bus.out_ovf, tbl[t].exp_ovf);
        chk({tbl[t].nm, "_in_rdy_out"}, bus.in_rdy, 0);
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
        chk({tbl[t].nm, "_idle_after_hs"}, bus.in_rdy, 1);
      end else begin
        chk({tbl[t].nm, "_out_vld_c6"}, bus.out_vld, 0);
        chk({tbl[t].nm, "_in_rdy_c6"}, bus.in_rdy, 1);
      end
    end

    // Back-pressure: result must hold while out_rdy is low.
    send(32'h04030201, 32'h08070605, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_vld", bus.out_vld, 1);
      chk("bp_out_acc", $signed(bus.out_acc), 70);
      chk("bp_in_rdy", bus.in_rdy, 0);
      @(negedge clk);
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    chk("bp_idle_in_rdy", bus.in_rdy, 1);
    chk("bp_idle_out_vld", bus.out_vld, 0);

    // Overflow: 128 beats of 4 x (-128*-128) reach exactly 2^23.
    for (int n = 0; n < 128; n++)
      send(32'h80808080, 32'h80808080, n == 0, n == 127);
    get_result("ovf", 0, racc, rovf);
    chk("ovf_acc", racc, -8388608);
    chk("ovf_flag", rovf, 1);
    send(32'h0, 32'h0, 1'b1, 1'b1);
    get_result("ovf_clear", 0, racc, rovf);
    chk("ovf_clear_acc", racc, 0);
    chk("ovf_clear_flag", rovf, 0);

    // Reset while issuing the third element.
    send(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_mul_vld", bus.mul_vld, 0);
    chk("mid_rst_mul_a", bus.mul_a, 0);
    chk("mid_rst_mul_b", bus.mul_b, 0);
    chk("mid_rst_out_vld", bus.out_vld, 0);
    chk("mid_rst_out_acc", bus.out_acc, 0);
    chk("mid_rst_in_rdy", bus.in_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", bus.in_rdy, 1);
    chk("post_rst_mul_vld", bus.mul_vld, 0);
    send(32'h04030201, 32'h08070605, 1'b0, 1'b1);
    get_result("post_rst", 0, racc, rovf);
    chk("post_rst_acc", racc, 70);
    chk("post_rst_ovf", rovf, 0);

    // Randomized beats against the arithmetic model.
    m_acc = 70;
    m_ovf = 1'b0;
    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ra = 32'h80808080;
        rb = 32'h80808080;
      end
      rf = (n == 0) || ($urandom_range(0, 5) == 0);
      rl = (n == 79) || ($urandom_range(0, 2) == 0);
      model_beat(ra, rb, rf);
      send(ra, rb, rf, rl);
      if (rl) begin
        get_result("rand", $urandom_range(0, 3), racc, rovf);
        chk("rand_acc", racc, m_acc);
        chk("rand_ovf", rovf, m_ovf);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
